game_round_ctrl: RTL and testbench
==================================

// Module: game_round_ctrl
// PURPOSE
//  Game-flow sequencer sitting directly upstream of vga_controller. Drives its screen-select flags
//  (logo, get_ready, times_up, leaderboard) and snitch_powerup. Checks both wands' 16-bit traced-cell
//  bitmaps against the current target rune and keeps per-player BCD scores and the round countdown
//  for the score-digit and trace displays.
// PARAMETERS
//  TICK_DIV        25_000_000  clk cycles per one-second tick (VGA pixel clock)
//  READY_SECS      3           get-ready screen duration, seconds
//  ROUND_SECS      60          play duration, seconds (<=99)
//  RESULT_SECS     5           times-up screen duration, seconds
//  SNITCH_PERIOD   15          snitch cycle length, seconds of play
//  SNITCH_SECS     4           snitch active window at end of each period (<SNITCH_PERIOD)
//  PTS_NORMAL      10          points per completed rune (binary, <=99)
//  PTS_SNITCH      30          points per completed rune while snitch_powerup=1
// PORTS
//  clk              in   1   pixel clock, sole clock
//  reset            in   1   synchronous, active-high
//  start            in   1   single-cycle start/restart pulse (debounced upstream)
//  two_player_mode  in   1   1: player 2 scored; 0: p2 inputs ignored
//  ir_in_p1         in   16  player-1 traced-cell bitmap (bit = 4x4 cell)
//  ir_in_p2         in   16  player-2 traced-cell bitmap
//  logo             out  1   1 only in IDLE
//  get_ready        out  1   1 only in READY
//  times_up         out  1   1 only in DONE
//  leaderboard      out  1   1 only in BOARD
//  snitch_powerup   out  1   power-up window active (PLAY only)
//  target_trace     out  16  current rune bitmap to display
//  p1_score_bcd     out  16  player-1 score, 4 BCD digits {thou,hund,tens,ones}
//  p2_score_bcd     out  16  player-2 score, 4 BCD digits
//  secs_left        out  7   seconds remaining in current timed state (binary)
// BEHAVIOUR
//  Reset: state=IDLE, logo=1, all other flags 0, scores 0, target_trace=PATTERN[0], secs_left=0,
//   tick counter 0, pattern index 0. Reset at any state aborts immediately, same values next cycle.
//  All outputs registered; state flags change the cycle after the transition condition.
//  Tick: tick_cnt counts 0..TICK_DIV-1, 1-cycle sec_tick at wrap; counter cleared on every state entry.
//  FSM (one-hot flags mutually exclusive):
//   IDLE  --start--> READY (scores cleared, pattern idx 0, secs_left=READY_SECS)
//   READY --secs_left hits 0 on sec_tick--> PLAY (secs_left=ROUND_SECS, elapsed=0)
//   PLAY  --secs_left hits 0 on sec_tick--> DONE (secs_left=RESULT_SECS); start ignored in PLAY
//   DONE  --secs_left hits 0 on sec_tick--> BOARD (secs_left=0)
//   BOARD --start--> READY. start in READY/DONE ignored.
//  secs_left decrements by 1 on each sec_tick in READY/PLAY/DONE.
//  Snitch: elapsed seconds counter in PLAY; snitch_powerup=1 iff PLAY and
//   (elapsed mod SNITCH_PERIOD) >= SNITCH_PERIOD-SNITCH_SECS. Forced 0 outside PLAY.
//  Match: mN = (ir_in_pN == target_trace), registered to mN_q. Score event when mN & ~mN_q & PLAY
//   (p2 also needs two_player_mode). Points = snitch_powerup ? PTS_SNITCH : PTS_NORMAL.
//  Both players same cycle: both score. Any score event advances pattern idx (mod 4) next cycle,
//   and forces m1_q=m2_q=1 so a stale bitmap matching the new rune does not score until it drops.
//  Score add is BCD; saturates at 9999 (never wraps). Scores hold through DONE/BOARD.
//  ir_in changes in READY/DONE/BOARD/IDLE never score.
// STRUCTURE
//  Package game_pkg: state enum {IDLE,READY,PLAY,DONE,BOARD}; PATTERN[0..3] = 16'hF99F,16'h6FF6,
//   16'h8421,16'hF00F; BCD_MAX=16'h9999.
//  Sub-module bcd_add_sat: 4-digit BCD + 2-digit BCD addend, combinational, saturating at 9999;
//   one instance per player. Points parameters converted to BCD at elaboration.
// TESTING  (TICK_DIV=4, READY_SECS=2, ROUND_SECS=6, RESULT_SECS=2, SNITCH_PERIOD=3, SNITCH_SECS=1)
//  Reset then idle 20 cycles -> logo=1, others 0, scores 16'h0000, target 16'hF99F.
//  start pulse -> get_ready=1 next cycle for 8 cycles, then PLAY 24 cycles, times_up 8, leaderboard=1.
//  PLAY: ir_in_p1=16'hF99F held 10 cycles -> p1 score 16'h0010 exactly once, target 16'h6FF6.
//  Match both players same cycle in snitch window (elapsed=2) -> p1 and p2 each +16'h0030.
//  p1 preset to 16'h9990, complete rune -> 16'h9999 (saturated); second rune -> still 16'h9999.
//  reset asserted mid-PLAY -> next cycle IDLE, logo=1, scores 0; start in PLAY ignored, timer unchanged.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow sequencer that feeds vga_controller.
package game_pkg;

    typedef enum logic [2:0] {IDLE, READY, PLAY, DONE, BOARD} game_state_t;

    localparam logic [15:0] PATTERN [4] = '{16'hF99F, 16'h6FF6, 16'h8421, 16'hF00F};
    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Two-digit BCD form of a small binary constant (0..99).
    function automatic logic [7:0] to_bcd2(input int unsigned value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage

// File: rtl/game_round_ctrl_bcd_add_sat.sv
// Four-digit BCD accumulator adder with a two-digit BCD addend; clamps at 9999 instead of wrapping.
module bcd_add_sat
    import game_pkg::*;
(
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic [15:0] sum
);

    logic [4:0]  digit;
    logic        carry;
    logic [15:0] raw;

    // Ripple digit by digit; a carry out of the thousands digit means overflow.
    always_comb begin
        digit = '0;
        carry = 1'b0;
        raw   = '0;
        for (int i = 0; i < 4; i++) begin
            digit = {1'b0, a[4*i +: 4]} + {4'b0000, carry};
            if (i < 2) begin
                digit = digit + {1'b0, b[4*i +: 4]};
            end
            if (digit > 5'd9) begin
                digit = digit - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            raw[4*i +: 4] = digit[3:0];
        end
        sum = carry ? BCD_MAX : raw;
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Game-flow sequencer: screen flags, rune matching, BCD scores, round timer and snitch window.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV      = 25_000_000,
    parameter int READY_SECS    = 3,
    parameter int ROUND_SECS    = 60,
    parameter int RESULT_SECS   = 5,
    parameter int SNITCH_PERIOD = 15,
    parameter int SNITCH_SECS   = 4,
    parameter int PTS_NORMAL    = 10,
    parameter int PTS_SNITCH    = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        two_player_mode,
    input  logic [15:0] ir_in_p1,
    input  logic [15:0] ir_in_p2,
    output logic        logo,
    output logic        get_ready,
    output logic        times_up,
    output logic        leaderboard,
    output logic        snitch_powerup,
    output logic [15:0] target_trace,
    output logic [15:0] p1_score_bcd,
    output logic [15:0] p2_score_bcd,
    output logic [6:0]  secs_left
);

    localparam int TICK_W  = $clog2(TICK_DIV + 1);
    localparam int PHASE_W = $clog2(SNITCH_PERIOD + 1);
    localparam logic [7:0] PTS_NORMAL_BCD = to_bcd2(PTS_NORMAL);
    localparam logic [7:0] PTS_SNITCH_BCD = to_bcd2(PTS_SNITCH);

    game_state_t        state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [PHASE_W-1:0] snitch_phase;
    logic [PHASE_W-1:0] phase_next;
    logic [1:0]         pat_idx;
    logic [1:0]         pat_next;
    logic               sec_tick;
    logic               m1, m2, m1_q, m2_q;
    logic               score1, score2;
    logic [7:0]         pts_bcd;
    logic [15:0]        p1_sum, p2_sum;

    assign sec_tick   = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign m1         = (ir_in_p1 == target_trace);
    assign m2         = (ir_in_p2 == target_trace);
    assign score1     = m1 & ~m1_q & (state == PLAY);
    assign score2     = m2 & ~m2_q & two_player_mode & (state == PLAY);
    assign pts_bcd    = snitch_powerup ? PTS_SNITCH_BCD : PTS_NORMAL_BCD;
    assign pat_next   = pat_idx + 2'd1;
    // Snitch phase is elapsed play seconds modulo SNITCH_PERIOD, kept as a wrapping counter.
    assign phase_next = (snitch_phase == PHASE_W'(SNITCH_PERIOD - 1)) ? '0 : snitch_phase + 1'b1;

    bcd_add_sat u_p1_add (.a(p1_score_bcd), .b(pts_bcd), .sum(p1_sum));
    bcd_add_sat u_p2_add (.a(p2_score_bcd), .b(pts_bcd), .sum(p2_sum));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            logo           <= 1'b1;
            get_ready      <= 1'b0;
            times_up       <= 1'b0;
            leaderboard    <= 1'b0;
            snitch_powerup <= 1'b0;
            tick_cnt       <= '0;
            snitch_phase   <= '0;
            secs_left      <= '0;
            pat_idx        <= '0;
            target_trace   <= PATTERN[0];
            p1_score_bcd   <= '0;
            p2_score_bcd   <= '0;
            m1_q           <= 1'b0;
            m2_q           <= 1'b0;
        end else begin
            tick_cnt <= sec_tick ? '0 : tick_cnt + 1'b1;
            m1_q     <= m1;
            m2_q     <= m2;
            if (score1) p1_score_bcd <= p1_sum;
            if (score2) p2_score_bcd <= p2_sum;
            // A completed rune moves on and blocks a stale bitmap from scoring the next one.
            if (score1 || score2) begin
                pat_idx      <= pat_next;
                target_trace <= PATTERN[pat_next];
                m1_q         <= 1'b1;
                m2_q         <= 1'b1;
            end
            case (state)
                IDLE, BOARD: begin
                    if (start) begin
                        state        <= READY;
                        logo         <= 1'b0;
                        leaderboard  <= 1'b0;
                        get_ready    <= 1'b1;
                        tick_cnt     <= '0;
                        secs_left    <= 7'(READY_SECS);
                        p1_score_bcd <= '0;
                        p2_score_bcd <= '0;
                        pat_idx      <= '0;
                        target_trace <= PATTERN[0];
                    end
                end
                READY: begin
                    if (sec_tick) begin
                        if (secs_left == 7'd1) begin
                            state        <= PLAY;
                            get_ready    <= 1'b0;
                            secs_left    <= 7'(ROUND_SECS);
                            snitch_phase <= '0;
                        end else begin
                            secs_left <= secs_left - 7'd1;
                        end
                    end
                end
                PLAY: begin
                    if (sec_tick) begin
                        if (secs_left == 7'd1) begin
                            state          <= DONE;
                            times_up       <= 1'b1;
                            snitch_powerup <= 1'b0;
                            secs_left      <= 7'(RESULT_SECS);
                        end else begin
                            secs_left      <= secs_left - 7'd1;
                            snitch_phase   <= phase_next;
                            snitch_powerup <= (phase_next >= PHASE_W'(SNITCH_PERIOD - SNITCH_SECS));
                        end
                    end
                end
                DONE: begin
                    if (sec_tick) begin
                        if (secs_left == 7'd1) begin
                            state       <= BOARD;
                            times_up    <= 1'b0;
                            leaderboard <= 1'b1;
                            secs_left   <= '0;
                        end else begin
                            secs_left <= secs_left - 7'd1;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    logo           <= 1'b1;
                    get_ready      <= 1'b0;
                    times_up       <= 1'b0;
                    leaderboard    <= 1'b0;
                    snitch_powerup <= 1'b0;
                    secs_left      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomised and directed bench for game_round_ctrl against a seconds-level behavioural model.
module tb_game_round_ctrl;

    localparam int TICK_DIV      = 4;
    localparam int READY_SECS    = 2;
    localparam int ROUND_SECS    = 6;
    localparam int RESULT_SECS   = 2;
    localparam int SNITCH_PERIOD = 3;
    localparam int SNITCH_SECS   = 1;
    localparam int PTS_NORMAL    = 10;
    localparam int PTS_SNITCH    = 30;
    localparam int SAT_PTS       = 99;

    localparam int PH_IDLE  = 0;
    localparam int PH_READY = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_DONE  = 3;
    localparam int PH_BOARD = 4;

    localparam logic [15:0] TB_PATTERN [4] = '{16'hF99F, 16'h6FF6, 16'h8421, 16'hF00F};

    logic        clk = 1'b0;
    logic        reset, start, two_player_mode;
    logic [15:0] ir_in_p1, ir_in_p2;
    logic        logo, get_ready, times_up, leaderboard, snitch_powerup;
    logic [15:0] target_trace, p1_score_bcd, p2_score_bcd;
    logic [6:0]  secs_left;

    logic        satStart;
    logic [15:0] satIr;
    logic        satLogo, satReady, satTimesUp, satBoard, satSnitch;
    logic [15:0] satTarget, satP1, satP2;
    logic [6:0]  satSecs;

    logic [15:0] addA, addSum;
    logic [7:0]  addB;

    int checkCount = 0;
    int errorCount = 0;

    int mPhase, mCycles, mScore1, mScore2, mIdx;
    bit mPrev1, mPrev2;

    always #5 clk = ~clk;

    game_round_ctrl #(
        .TICK_DIV(TICK_DIV), .READY_SECS(READY_SECS), .ROUND_SECS(ROUND_SECS),
        .RESULT_SECS(RESULT_SECS), .SNITCH_PERIOD(SNITCH_PERIOD), .SNITCH_SECS(SNITCH_SECS),
        .PTS_NORMAL(PTS_NORMAL), .PTS_SNITCH(PTS_SNITCH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .two_player_mode(two_player_mode),
        .ir_in_p1(ir_in_p1), .ir_in_p2(ir_in_p2), .logo(logo), .get_ready(get_ready),
        .times_up(times_up), .leaderboard(leaderboard), .snitch_powerup(snitch_powerup),
        .target_trace(target_trace), .p1_score_bcd(p1_score_bcd), .p2_score_bcd(p2_score_bcd),
        .secs_left(secs_left)
    );

    game_round_ctrl #(
        .TICK_DIV(TICK_DIV), .READY_SECS(READY_SECS), .ROUND_SECS(99),
        .RESULT_SECS(RESULT_SECS), .SNITCH_PERIOD(SNITCH_PERIOD), .SNITCH_SECS(SNITCH_SECS),
        .PTS_NORMAL(SAT_PTS), .PTS_SNITCH(SAT_PTS)
    ) dutSat (
        .clk(clk), .reset(reset), .start(satStart), .two_player_mode(1'b0),
        .ir_in_p1(satIr), .ir_in_p2(16'h0000), .logo(satLogo), .get_ready(satReady),
        .times_up(satTimesUp), .leaderboard(satBoard), .snitch_powerup(satSnitch),
        .target_trace(satTarget), .p1_score_bcd(satP1), .p2_score_bcd(satP2),
        .secs_left(satSecs)
    );

    bcd_add_sat uAdd (.a(addA), .b(addB), .sum(addSum));

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int satAdd(input int a, input int b);
        return (a + b > 9999) ? 9999 : a + b;
    endfunction

    function automatic int phaseSeconds(input int ph);
        case (ph)
            PH_READY: return READY_SECS;
            PH_PLAY:  return ROUND_SECS;
            PH_DONE:  return RESULT_SECS;
            default:  return 0;
        endcase
    endfunction

    function automatic bit modelSnitch();
        return (mPhase == PH_PLAY) &&
               (((mCycles / TICK_DIV) % SNITCH_PERIOD) >= SNITCH_PERIOD - SNITCH_SECS);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit tp, input logic [15:0] a, input logic [15:0] b);
        start           = st;
        two_player_mode = tp;
        ir_in_p1        = a;
        ir_in_p2        = b;
    endtask

    // Advances the reference by one clock using the inputs that were present at the edge.
    task automatic modelStep();
        bit match1, match2, ev1, ev2;
        int pts;
        if (reset) begin
            mPhase = PH_IDLE; mCycles = 0; mScore1 = 0; mScore2 = 0;
            mIdx = 0; mPrev1 = 0; mPrev2 = 0;
            return;
        end
        match1 = (ir_in_p1 == TB_PATTERN[mIdx]);
        match2 = (ir_in_p2 == TB_PATTERN[mIdx]);
        ev1 = (mPhase == PH_PLAY) && match1 && !mPrev1;
        ev2 = (mPhase == PH_PLAY) && two_player_mode && match2 && !mPrev2;
        pts = modelSnitch() ? PTS_SNITCH : PTS_NORMAL;
        if (ev1) mScore1 = satAdd(mScore1, pts);
        if (ev2) mScore2 = satAdd(mScore2, pts);
        if (ev1 || ev2) begin
            mIdx = (mIdx + 1) % 4; mPrev1 = 1; mPrev2 = 1;
        end else begin
            mPrev1 = match1; mPrev2 = match2;
        end
        if (mPhase == PH_IDLE || mPhase == PH_BOARD) begin
            if (start) begin
                mPhase = PH_READY; mCycles = 0; mScore1 = 0; mScore2 = 0; mIdx = 0;
            end
        end else begin
            mCycles++;
            if (mCycles == phaseSeconds(mPhase) * TICK_DIV) begin
                mPhase++;
                mCycles = 0;
            end
        end
    endtask

    task automatic compareAll();
        int secsExp;
        secsExp = (mPhase == PH_IDLE || mPhase == PH_BOARD) ? 0
                : phaseSeconds(mPhase) - mCycles / TICK_DIV;
        checkOutput("logo", logo, mPhase == PH_IDLE);
        checkOutput("get_ready", get_ready, mPhase == PH_READY);
        checkOutput("times_up", times_up, mPhase == PH_DONE);
        checkOutput("leaderboard", leaderboard, mPhase == PH_BOARD);
        checkOutput("snitch", snitch_powerup, modelSnitch());
        checkOutput("target", target_trace, TB_PATTERN[mIdx]);
        checkOutput("p1_score", p1_score_bcd, toBcd(mScore1));
        checkOutput("p2_score", p2_score_bcd, toBcd(mScore2));
        checkOutput("secs_left", secs_left, secsExp);
    endtask

    task automatic runCycle();
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    function automatic logic [15:0] randomIr(input logic [15:0] current);
        case ($urandom_range(0, 3))
            0:       return TB_PATTERN[mIdx];
            1:       return TB_PATTERN[$urandom_range(0, 3)];
            2:       return 16'($urandom);
            default: return current;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        int runes;
        int a, b;
        reset = 1'b1;
        satStart = 1'b0;
        satIr = 16'h0000;
        addA = '0;
        addB = '0;
        applyStimulus(0, 0, 16'h0000, 16'h0000);
        repeat (3) runCycle();
        reset = 1'b0;
        repeat (20) runCycle();
        checkOutput("idle_logo", logo, 1);
        checkOutput("idle_target", target_trace, 16'hF99F);
        checkOutput("idle_p1", p1_score_bcd, 16'h0000);

        // First round: timings, single score, simultaneous snitch score.
        applyStimulus(1, 1, 16'h0000, 16'h0000);
        runCycle();
        applyStimulus(0, 1, 16'h0000, 16'h0000);
        cnt = 0;
        while (get_ready === 1'b1 && cnt < 100) begin
            cnt++;
            runCycle();
        end
        checkOutput("ready_len", cnt, 8);
        applyStimulus(0, 1, 16'hF99F, 16'h0000);
        repeat (8) runCycle();
        checkOutput("p1_first_rune", p1_score_bcd, 16'h0010);
        checkOutput("target_after_rune", target_trace, 16'h6FF6);
        checkOutput("snitch_window", snitch_powerup, 1);
        applyStimulus(0, 1, 16'h6FF6, 16'h6FF6);
        runCycle();
        checkOutput("p1_snitch", p1_score_bcd, 16'h0040);
        checkOutput("p2_snitch", p2_score_bcd, 16'h0030);
        applyStimulus(0, 1, 16'h0000, 16'h0000);
        cnt = 10;
        while (times_up !== 1'b1 && cnt < 200) begin
            runCycle();
            if (times_up !== 1'b1) cnt++;
        end
        checkOutput("play_len", cnt, 24);
        cnt = 0;
        while (times_up === 1'b1 && cnt < 100) begin
            cnt++;
            runCycle();
        end
        checkOutput("done_len", cnt, 8);
        checkOutput("board_flag", leaderboard, 1);
        checkOutput("board_p1_hold", p1_score_bcd, 16'h0040);

        // Second round: start ignored in PLAY, then reset mid-PLAY.
        applyStimulus(1, 0, 16'h0000, 16'h0000);
        runCycle();
        applyStimulus(0, 0, 16'h0000, 16'h0000);
        repeat (8) runCycle();
        applyStimulus(0, 0, 16'hF99F, 16'h0000);
        repeat (5) runCycle();
        applyStimulus(1, 0, 16'hF99F, 16'h0000);
        runCycle();
        applyStimulus(0, 0, 16'hF99F, 16'h0000);
        checkOutput("start_in_play_ready", get_ready, 0);
        checkOutput("start_in_play_secs", secs_left, 5);
        checkOutput("round2_p1", p1_score_bcd, 16'h0010);
        reset = 1'b1;
        runCycle();
        reset = 1'b0;
        checkOutput("midplay_reset_logo", logo, 1);
        checkOutput("midplay_reset_p1", p1_score_bcd, 16'h0000);
        checkOutput("midplay_reset_secs", secs_left, 0);

        // Random traffic across many rounds.
        for (int i = 0; i < 1200; i++) begin
            applyStimulus($urandom_range(0, 9) == 0, 1'($urandom), randomIr(ir_in_p1), randomIr(ir_in_p2));
            reset = ($urandom_range(0, 299) == 0);
            runCycle();
        end
        reset = 1'b1;
        applyStimulus(0, 0, 16'h0000, 16'h0000);
        runCycle();
        reset = 1'b0;

        // Saturation: 99-point runes on the long-round instance.
        satStart = 1'b1;
        runCycle();
        satStart = 1'b0;
        repeat (8) runCycle();
        checkOutput("sat_in_play", satSecs, 99);
        for (runes = 1; runes <= 103; runes++) begin
            satIr = TB_PATTERN[(runes - 1) % 4];
            runCycle();
            runCycle();
            checkOutput("sat_score", satP1, toBcd((runes * SAT_PTS > 9999) ? 9999 : runes * SAT_PTS));
        end
        checkOutput("sat_final", satP1, 16'h9999);
        checkOutput("sat_p2_ignored", satP2, 16'h0000);

        // Adder vectors, including the 9990 + 10 clamp.
        addA = toBcd(9990); addB = 8'h10; #1;
        checkOutput("add_9990_10", addSum, 16'h9999);
        addA = toBcd(9999); addB = 8'h00; #1;
        checkOutput("add_9999_0", addSum, 16'h9999);
        addA = toBcd(1234); addB = 8'h99; #1;
        checkOutput("add_1234_99", addSum, 16'h1333);
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 9999);
            b = $urandom_range(0, 99);
            addA = toBcd(a);
            addB = 8'(toBcd(b));
            #1;
            checkOutput("add_random", addSum, toBcd(satAdd(a, b)));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
